riscv_divider: RTL and testbench
================================

Name: riscv_divider

Overview:
Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the W variants. Sits in the execute stage, directly downstream of the decode/execute pipeline register. Takes rs1/rs2 execute-stage data and the M-extension op. Raises a stall request to the hazard unit while computing, and returns a registered result to the execute result mux.

Parameters:
XLEN, 64, datapath width; W ops use the low 32 bits and require XLEN=64

Ports:
i_riscv_div_clk  in  1  clock, rising edge
i_riscv_div_rst  in  1  reset, asynchronous, active-high
i_riscv_div_start  in  1  execute-stage instruction is a divide op, operands valid
i_riscv_div_kill  in  1  flush from hazard unit; abort any operation in flight
i_riscv_div_op  in  3  bit0 unsigned, bit1 remainder (else quotient), bit2 word (32-bit)
i_riscv_div_rs1data  in  XLEN  dividend (forwarded rs1 value)
i_riscv_div_rs2data  in  XLEN  divisor (forwarded rs2 value)
o_riscv_div_result  out  XLEN  quotient/remainder; valid only while o_riscv_div_valid=1
o_riscv_div_valid  out  1  one-cycle result strobe
o_riscv_div_busy  out  1  stall request to hazard unit (combinational)

Behaviour:
- States: IDLE, CALC, DONE. Reset: state=IDLE, result=0, valid=0, iteration counter=0, all internal operand registers=0.
- IDLE, start=1, kill=0: latch operands and op at the edge.
  - W: operands = low 32 bits, sign- or zero-extended per bit0.
  - Signed: store magnitudes plus quotient sign (sa^sb) and remainder sign (sa).
- Special-case results (IDLE -> DONE, result written at that edge):
  - Divisor==0: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = most-negative, divisor = -1, at the operating width): quotient = dividend; remainder = 0.
- Otherwise IDLE -> CALC with counter = 64, or 32 for W ops.
- CALC, each cycle:
  - remainder = (remainder<<1) | dividend MSB; shift the dividend left.
  - If remainder >= divisor: subtract and shift in quotient bit 1, else shift in 0.
  - Decrement the counter; at counter==1 the transition goes to DONE.
  - On the final edge, apply the sign fix-up (negate quotient/remainder per stored signs) and write the result register.
- W results: sign-extend bit 31 of the 32-bit result to XLEN for all W ops, including DIVUW/REMUW.
- DONE: valid=1 for exactly one cycle, then IDLE. Result register holds its value until the next write.
- busy = (IDLE & start & ~kill) | CALC. busy=0 in DONE, so the stalled instruction advances in the same cycle valid=1.
- Latency (start sampled in cycle 0):
  - 64-bit: valid in cycle 65.
  - W: valid in cycle 33.
  - Special cases: valid in cycle 1.
- start while in CALC or DONE is ignored; it must not restart or corrupt the operation.
- kill in any state: next state IDLE, valid stays 0 next cycle, result not written. kill and start together in IDLE: kill wins.
- Reset mid-CALC: immediate return to IDLE with all registers cleared; no valid pulse.

Optional Feature:
RISCV_DIV_EARLY_OUT_EN
- Defined: in IDLE, if |dividend| < |divisor| (unsigned compare of the latched magnitudes, operating width, divisor nonzero), go straight to DONE.
  - Quotient = 0; remainder = original signed/unsigned dividend (W: sign-extended).
  - Valid in cycle 1.
- Undefined: these cases take the full 64/32 iterations. Results are bit-identical either way.

Decomposition:
- Package riscv_div_pkg:
  - state enum (IDLE, CALC, DONE);
  - localparams for the op bit positions (DIV_UNSIGNED_BIT=0, DIV_REM_BIT=1, DIV_WORD_BIT=2);
  - iteration counts (DIV_ITER_D=64, DIV_ITER_W=32).
- One sub-module, riscv_div_step: combinational shift/compare/subtract for one iteration (inputs rem, dividend MSB, divisor; outputs next rem and quotient bit). Instantiated once.

Test Plan:
- DIV rs1=-7, rs2=2 -> result 0xFFFF_FFFF_FFFF_FFFD (-3); REM same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1); valid in cycle 65, busy high cycles 0-64.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; without the macro, valid in cycle 65; with RISCV_DIV_EARLY_OUT_EN, REMU 3/7 -> 3 valid in cycle 1.
- Divide by zero:
  - DIV 5/0 -> 0xFFFF_FFFF_FFFF_FFFF;
  - REMU 5/0 -> 5;
  - DIVW 5/0 -> 0xFFFF_FFFF_FFFF_FFFF;
  - each with valid in cycle 1.
- Overflow:
  - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM -> 0;
  - DIVW rs1=0x0000_0001_8000_0000, rs2=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
- DIVUW rs1=0xFFFF_FFFF, rs2=1 -> 0xFFFF_FFFF_FFFF_FFFF; valid in cycle 33.
- kill asserted in cycle 20 of a DIVU -> IDLE next cycle, no valid pulse, result unchanged. A new DIVU 9/3 started right after -> 3 in cycle 65 of the new op. Async reset mid-CALC -> all outputs 0 immediately.

Source files
------------

// File: rtl/riscv_div_pkg.sv
// Shared types and constants for the RV64M iterative divider.
package riscv_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_UNSIGNED_BIT = 0;
  localparam int DIV_REM_BIT      = 1;
  localparam int DIV_WORD_BIT     = 2;

  localparam int DIV_ITER_D = 64;
  localparam int DIV_ITER_W = 32;

endpackage

// File: rtl/riscv_div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract the divisor.
module riscv_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dividend_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // One extra bit so the shifted partial remainder never overflows the compare.
  always_comb begin
    shifted  = {rem, dividend_msb};
    diff     = shifted - {1'b0, divisor};
    q_bit    = (shifted >= {1'b0, divisor});
    rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/riscv_divider.sv
// Iterative RV64M divider (DIV/DIVU/REM/REMU and W forms), one quotient bit per cycle.
// Optional build macro RISCV_DIV_EARLY_OUT_EN finishes |dividend| < |divisor| cases immediately.
module riscv_divider
  import riscv_div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            i_riscv_div_clk,
  input  logic            i_riscv_div_rst,
  input  logic            i_riscv_div_start,
  input  logic            i_riscv_div_kill,
  input  logic [2:0]      i_riscv_div_op,
  input  logic [XLEN-1:0] i_riscv_div_rs1data,
  input  logic [XLEN-1:0] i_riscv_div_rs2data,
  output logic [XLEN-1:0] o_riscv_div_result,
  output logic            o_riscv_div_valid,
  output logic            o_riscv_div_busy
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] word_sext(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] word_zext(input logic [XLEN-1:0] v);
    return {{(XLEN-32){1'b0}}, v[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] sign_fixup(input logic [XLEN-1:0] q, input logic [XLEN-1:0] r,
                                                 input logic neg_q, input logic neg_r,
                                                 input logic sel_rem, input logic word);
    logic [XLEN-1:0] q_s;
    logic [XLEN-1:0] r_s;
    logic [XLEN-1:0] res;
    q_s = neg_q ? -q : q;
    r_s = neg_r ? -r : r;
    res = sel_rem ? r_s : q_s;
    return word ? word_sext(res) : res;
  endfunction

  div_state_t      state, state_next;
  logic [6:0]      cnt;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] result_r;
  logic            neg_q, neg_r, op_rem_r, op_word_r;

  logic            op_unsigned, op_rem, op_word;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
  logic            sa, sb;
  logic            div_zero, ovf, early, special;
  logic [XLEN-1:0] special_res;
  logic            start_ok;

  logic [XLEN-1:0] rem_next;
  logic            q_bit;
  logic [XLEN-1:0] q_next;
  logic [XLEN-1:0] calc_res;

  // Operand preparation for the IDLE-cycle latch
  always_comb begin
    op_unsigned = i_riscv_div_op[DIV_UNSIGNED_BIT];
    op_rem      = i_riscv_div_op[DIV_REM_BIT];
    op_word     = i_riscv_div_op[DIV_WORD_BIT];
    a_ext = op_word ? (op_unsigned ? word_zext(i_riscv_div_rs1data) : word_sext(i_riscv_div_rs1data))
                    : i_riscv_div_rs1data;
    b_ext = op_word ? (op_unsigned ? word_zext(i_riscv_div_rs2data) : word_sext(i_riscv_div_rs2data))
                    : i_riscv_div_rs2data;
    sa    = ~op_unsigned & a_ext[XLEN-1];
    sb    = ~op_unsigned & b_ext[XLEN-1];
    a_mag = sa ? -a_ext : a_ext;
    b_mag = sb ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    ovf      = ~op_unsigned & (b_ext == '1) &
               (op_word ? (a_ext[31:0] == 32'h8000_0000) : (a_ext == MOST_NEG));
`ifdef RISCV_DIV_EARLY_OUT_EN
    early    = ~div_zero & (a_mag < b_mag);
`else
    early    = 1'b0;
`endif
    special  = div_zero | ovf | early;
    if (div_zero)  special_res = op_rem ? a_ext : '1;
    else if (ovf)  special_res = op_rem ? '0 : a_ext;
    else           special_res = op_rem ? a_ext : '0;
    if (op_word) special_res = word_sext(special_res);
    start_ok = (state == IDLE) & i_riscv_div_start & ~i_riscv_div_kill;
  end

  riscv_div_step #(.XLEN(XLEN)) u_step (
    .rem          (rem_r),
    .dividend_msb (dvd[XLEN-1]),
    .divisor      (dvs),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  always_comb begin
    q_next   = {dvd[XLEN-2:0], q_bit};
    calc_res = sign_fixup(q_next, rem_next, neg_q, neg_r, op_rem_r, op_word_r);
  end

  always_ff @(posedge i_riscv_div_clk or posedge i_riscv_div_rst) begin
    if (i_riscv_div_rst) state <= IDLE;
    else                 state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = special ? DONE : CALC;
      CALC:    if (i_riscv_div_kill) state_next = IDLE;
               else if (cnt == 7'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_riscv_div_busy   = start_ok | (state == CALC);
    o_riscv_div_valid  = (state == DONE);
    o_riscv_div_result = result_r;
  end

  // W operands sit in the upper half so the MSB tap sees them from the first step;
  // quotient bits fill in from the bottom as the dividend shifts out.
  always_ff @(posedge i_riscv_div_clk or posedge i_riscv_div_rst) begin
    if (i_riscv_div_rst) begin
      cnt       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      rem_r     <= '0;
      result_r  <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      op_rem_r  <= 1'b0;
      op_word_r <= 1'b0;
    end else if (start_ok) begin
      dvd       <= op_word ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
      dvs       <= b_mag;
      rem_r     <= '0;
      neg_q     <= sa ^ sb;
      neg_r     <= sa;
      op_rem_r  <= op_rem;
      op_word_r <= op_word;
      cnt       <= op_word ? 7'(DIV_ITER_W) : 7'(DIV_ITER_D);
      if (special) result_r <= special_res;
    end else if ((state == CALC) && !i_riscv_div_kill) begin
      rem_r <= rem_next;
      dvd   <= q_next;
      cnt   <= cnt - 7'd1;
      if (cnt == 7'd1) result_r <= calc_res;
    end
  end

endmodule

// File: tb/tb_riscv_divider.sv
// Directed-vector bench for riscv_divider; latency expectations follow RISCV_DIV_EARLY_OUT_EN.
module tb_riscv_divider;

  localparam int XLEN = 64;
`ifdef RISCV_DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 65;
`endif

  logic            clk;
  logic            rst;
  logic            start;
  logic            kill;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1, rs2;
  logic [XLEN-1:0] result;
  logic            valid;
  logic            busy;

  int errors = 0;
  int checks = 0;

  riscv_divider #(.XLEN(XLEN)) dut (
    .i_riscv_div_clk     (clk),
    .i_riscv_div_rst     (rst),
    .i_riscv_div_start   (start),
    .i_riscv_div_kill    (kill),
    .i_riscv_div_op      (op),
    .i_riscv_div_rs1data (rs1),
    .i_riscv_div_rs2data (rs2),
    .o_riscv_div_result  (result),
    .o_riscv_div_valid   (valid),
    .o_riscv_div_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Issue one op (start high in cycle 0) and follow it to the valid strobe.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_res,
                        input int exp_lat, input bit glitch);
    int cyc;
    int bad;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    #1 chk({tag, " busy_c0"}, 64'(busy), 64'd1);
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    bad = 0;
    @(negedge clk);
    while (!valid && cyc < 100) begin
      if (!busy) bad++;
      if (glitch && cyc == 10) begin
        start = 1'b1; op = 3'b000; rs1 = '1; rs2 = 64'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, " result"}, result, exp_res);
    chk({tag, " busy_low"}, 64'(busy), 64'd0);
    if (exp_lat > 1) chk({tag, " busy_calc"}, 64'(bad), 64'd0);
    @(negedge clk);
    chk({tag, " valid_1cyc"}, 64'(valid), 64'd0);
  endtask

  initial begin
    int vcount;
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(negedge clk);
    chk("reset result", result, 64'd0);
    chk("reset valid", 64'(valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("DIV -7/2",  3'b000, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b0);
    run_op("REM -7/2",  3'b010, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0);
    run_op("DIVU 100/7", 3'b001, 64'd100, 64'd7, 64'd14, 65, 1'b1);
    run_op("REMU 100/7", 3'b011, 64'd100, 64'd7, 64'd2, 65, 1'b0);
    run_op("REMU 3/7",  3'b011, 64'd3, 64'd7, 64'd3, EO_LAT, 1'b0);
    run_op("DIV 5/0",   3'b000, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
    run_op("REMU 5/0",  3'b011, 64'd5, 64'd0, 64'd5, 1, 1'b0);
    run_op("DIVW 5/0",  3'b100, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
    run_op("DIV ovf",   3'b000, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 1'b0);
    run_op("REM ovf",   3'b010, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 1'b0);
    run_op("DIVW ovf",  3'b100, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1, 1'b0);
    run_op("DIVUW",     3'b101, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33, 1'b0);
    run_op("REMW -7/2", 3'b110, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 1'b0);

    // Kill in cycle 20 of a DIVU; last written result is 0xFFFF_FFFF_FFFF_FFFF.
    @(negedge clk);
    start = 1'b1; op = 3'b001; rs1 = 64'd1000; rs2 = 64'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill busy", 64'(busy), 64'd0);
    chk("kill valid", 64'(valid), 64'd0);
    chk("kill result", result, 64'hFFFF_FFFF_FFFF_FFFF);
    vcount = 0;
    repeat (70) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    chk("kill no_valid", 64'(vcount), 64'd0);
    run_op("DIVU 9/3",  3'b001, 64'd9, 64'd3, 64'd3, 65, 1'b0);

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk);
    start = 1'b1; op = 3'b001; rs1 = 64'd1000; rs2 = 64'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst result", result, 64'd0);
    chk("arst valid", 64'(valid), 64'd0);
    chk("arst busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    repeat (70) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    chk("arst no_valid", 64'(vcount), 64'd0);
    run_op("DIVU 1000/7", 3'b001, 64'd1000, 64'd7, 64'd142, 65, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
